// File: rtl/dma_hold_arbiter_if.sv
// Bus-hold handshake bundle between the DMA hold arbiter, the CPU and the DMA requesters.
// The master modport is the arbiter side; the slave modport is the requester/CPU side.
interface dma_hold_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0] hold_req;
  logic             cpu_idle;
  logic [N_REQ-1:0] clr_overrun;
  logic [N_REQ-1:0] hold_ack;
  logic             cpu_stall;
  logic [2:0]       bus_owner;
  logic [N_REQ-1:0] overrun;
  logic             irq;

  modport master (
    input  hold_req,
    input  cpu_idle,
    input  clr_overrun,
    output hold_ack,
    output cpu_stall,
    output bus_owner,
    output overrun,
    output irq
  );

  modport slave (
    output hold_req,
    output cpu_idle,
    output clr_overrun,
    input  hold_ack,
    input  cpu_stall,
    input  bus_owner,
    input  overrun,
    input  irq
  );
endinterface

// File: rtl/dma_hold_arbiter.sv
// Round-robin HOLD/HOLD_ACK arbiter for the external memory bus. Stalls the CPU at a safe
// point, grants one DMA requester at a time, guarantees a CPU slot between grants and flags
// requesters whose grant reaches MAX_HOLD cycles.
module dma_hold_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned CPU_SLOT = 4,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  dma_hold_arbiter_if.master bus
);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned SlotW = (CPU_SLOT == 0) ? 1 : $clog2(CPU_SLOT + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MAX_HOLD);
  localparam logic [SlotW-1:0] SlotLoad = SlotW'(CPU_SLOT);
  // Requester 0 wins the first tie after reset.
  localparam logic [2:0]       LastInit = 3'(N_REQ - 1);

  typedef enum logic [1:0] {StCpuOwn, StStall, StGrant, StRelease} state_e;

  state_e           state_q, state_d;
  logic [2:0]       winner_q, winner_d;
  logic [2:0]       last_q, last_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] ovr_q, ovr_d;
  logic [2:0]       owner_q, owner_d;
  logic             stall_q, stall_d;
  logic             irq_q, irq_d;
  logic [2:0]       rr_pick;
  logic             rr_any;
  logic             win_req;
  logic             ovr_set;

  // Round-robin pick: first requester above last_grant, else first from 0 upwards.
  always_comb begin
    rr_pick = '0;
    rr_any  = |bus.hold_req;
    for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
      if (bus.hold_req[j] && (j <= int'(last_q))) rr_pick = 3'(j);
    end
    // Second pass overrides the wrap-around candidates.
    for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
      if (bus.hold_req[j] && (j > int'(last_q))) rr_pick = 3'(j);
    end
  end

  // HOLD level of the currently latched winner.
  always_comb begin
    win_req = 1'b0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (3'(j) == winner_q) win_req = bus.hold_req[j];
    end
  end

  // Next-state logic: arbitration, safe-point stall, grant timing and CPU slot countdown.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    slot_d     = slot_q;
    ovr_set    = 1'b0;
    unique case (state_q)
      StCpuOwn: begin
        if ((slot_q == '0) && rr_any) begin
          winner_d = rr_pick;
          state_d  = StStall;
        end else if (slot_q != '0) begin
          slot_d = slot_q - 1'b1;
        end
      end
      StStall: begin
        // Requester gave up before the CPU reached a safe point: no grant, no CPU slot.
        if (!win_req) begin
          state_d = StCpuOwn;
        end else if (bus.cpu_idle) begin
          state_d    = StGrant;
          last_d     = winner_q;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          ovr_set    = ((hold_cnt_q + 1'b1) == HoldMax);
        end
        if (!win_req) state_d = StRelease;
      end
      StRelease: begin
        slot_d  = SlotLoad;
        state_d = StCpuOwn;
      end
      default: state_d = StCpuOwn;
    endcase
  end

  // Output decode from next state, so every output leaves a flop.
  always_comb begin
    stall_d = (state_d != StCpuOwn);
    ack_d   = '0;
    owner_d = '0;
    if (state_d == StGrant) begin
      for (int j = 0; j < int'(N_REQ); j++) begin
        ack_d[j] = (3'(j) == winner_d);
      end
      owner_d = winner_d + 3'd1;
    end
    // Clear first, then set, so a coincident set wins.
    ovr_d = ovr_q & ~bus.clr_overrun;
    if (ovr_set) begin
      for (int j = 0; j < int'(N_REQ); j++) begin
        if (3'(j) == winner_q) ovr_d[j] = 1'b1;
      end
    end
    irq_d = |ovr_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StCpuOwn;
      winner_q   <= '0;
      last_q     <= LastInit;
      hold_cnt_q <= '0;
      slot_q     <= '0;
      ack_q      <= '0;
      ovr_q      <= '0;
      owner_q    <= '0;
      stall_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      slot_q     <= slot_d;
      ack_q      <= ack_d;
      ovr_q      <= ovr_d;
      owner_q    <= owner_d;
      stall_q    <= stall_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.hold_ack  = ack_q;
  assign bus.cpu_stall = stall_q;
  assign bus.bus_owner = owner_q;
  assign bus.overrun   = ovr_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Randomized scoreboard bench for dma_hold_arbiter. The driver plans each bus-hold
// transaction from the timing rules (arbitration edge, safe-point delay, grant length,
// CPU slot) and queues the expected observation; a negedge monitor reconstructs each
// transaction from the DUT outputs and compares when cpu_stall falls.
module tb_dma_hold_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned CS = 4;
  localparam int unsigned MH = 16;
  localparam int          NTXN = 40;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  dma_hold_arbiter_if #(.N_REQ(N)) bus ();

  dma_hold_arbiter #(
    .N_REQ   (N),
    .CPU_SLOT(CS),
    .MAX_HOLD(MH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge E settles, cyc == E.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int w;       // granted requester, -1 if no grant
    int s_rise;  // edge after which cpu_stall rises
    int a_rise;  // edge after which hold_ack rises, -1 if none
    int a_len;   // cycles hold_ack is high
    int o_cyc;   // edge after which overrun first shows, -1 if none
    int o_bits;  // overrun vector when first seen
    int s_fall;  // edge after which cpu_stall falls
  } txn_t;

  txn_t exp_q[$];
  txn_t obs;
  txn_t ex;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_winner(input logic [N-1:0] mask, input int last);
    for (int i = 1; i <= int'(N); i++) begin
      if (((mask >> ((last + i) % int'(N))) & N'(1)) != '0) return (last + i) % int'(N);
    end
    return -1;
  endfunction

  // Monitor
  bit   mon_en     = 1'b0;
  logic prev_stall = 1'b0;
  int   mon_own;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_own = -1;
      for (int j = 0; j < int'(N); j++) if (bus.hold_ack[j]) mon_own = j;
      chk("ack_onehot", int'($countones(bus.hold_ack) <= 1), 1);
      chk("bus_owner", int'(bus.bus_owner), (mon_own < 0) ? 0 : mon_own + 1);
      chk("irq_or", int'(bus.irq), int'(|bus.overrun));
      if (mon_own >= 0) chk("ack_implies_stall", int'(bus.cpu_stall), 1);
      if (bus.cpu_stall && !prev_stall) begin
        obs.s_rise = cyc;
        obs.w      = -1;
        obs.a_rise = -1;
        obs.a_len  = 0;
        obs.o_cyc  = -1;
        obs.o_bits = 0;
        chk("overrun_cleared_at_arb", int'(bus.overrun), 0);
      end
      if (bus.cpu_stall) begin
        if (mon_own >= 0) begin
          if (obs.a_rise < 0) begin
            obs.a_rise = cyc;
            obs.w      = mon_own;
          end
          obs.a_len++;
        end
        if ((bus.overrun != '0) && (obs.o_cyc < 0)) begin
          obs.o_cyc  = cyc;
          obs.o_bits = int'(bus.overrun);
        end
      end
      if (!bus.cpu_stall && prev_stall) begin
        chk("txn_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ex = exp_q.pop_front();
          chk("stall_rise_cyc", obs.s_rise, ex.s_rise);
          chk("grant_winner", obs.w, ex.w);
          chk("ack_rise_cyc", obs.a_rise, ex.a_rise);
          chk("ack_len", obs.a_len, ex.a_len);
          chk("overrun_cyc", obs.o_cyc, ex.o_cyc);
          chk("overrun_bits", obs.o_bits, ex.o_bits);
          chk("stall_fall_cyc", cyc, ex.s_fall);
        end
      end
      prev_stall = bus.cpu_stall;
    end
  end

  // Driver and reference timing model
  initial begin
    int last, ready, cur, g, m, len, k, a_edge, g_edge, n_edge, drop, first_seen, w, rst_cyc;
    bit abort, coinc;
    logic [N-1:0] mask, hr;
    txn_t et;

    bus.hold_req    = '0;
    bus.cpu_idle    = 1'b1;
    bus.clr_overrun = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_hold_ack", int'(bus.hold_ack), 0);
    chk("rst_cpu_stall", int'(bus.cpu_stall), 0);
    chk("rst_bus_owner", int'(bus.bus_owner), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_irq", int'(bus.irq), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    cur     = cyc;
    last    = int'(N) - 1;
    ready   = 0;
    mon_en  = 1'b1;

    for (int t = 0; t < NTXN; t++) begin
      mask  = N'($urandom_range(1, (1 << N) - 1));
      g     = int'($urandom_range(0, 8));
      m     = int'($urandom_range(0, 3));
      len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MH, MH + 6))
                                          : int'($urandom_range(1, MH - 1));
      abort = (m > 0) && ($urandom_range(0, 5) == 0);
      k     = (m > 0) ? int'($urandom_range(1, m)) : 0;
      coinc = ($urandom_range(0, 1) == 1);

      first_seen = cur + 1 + g;
      a_edge     = (ready > first_seen) ? ready : first_seen;
      w          = rr_winner(mask, last);
      g_edge     = a_edge + m + 1;
      n_edge     = g_edge + len;
      drop       = abort ? (a_edge + k) : n_edge;

      et.s_rise = a_edge;
      if (abort) begin
        et.w      = -1;
        et.a_rise = -1;
        et.a_len  = 0;
        et.o_cyc  = -1;
        et.o_bits = 0;
        et.s_fall = a_edge + k;
      end else begin
        et.w      = w;
        et.a_rise = g_edge;
        et.a_len  = len;
        et.o_cyc  = (len >= int'(MH)) ? g_edge + int'(MH) : -1;
        et.o_bits = (len >= int'(MH)) ? (1 << w) : 0;
        et.s_fall = n_edge + 1;
      end
      exp_q.push_back(et);

      for (int e = cur + 1; e <= drop; e++) begin
        if (e < first_seen) begin
          hr = (e < ready) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
        end else if (e <= a_edge) begin
          hr = mask;
        end else if (e < drop) begin
          hr = N'($urandom_range(0, (1 << N) - 1)) | (N'(1) << w);
        end else if (abort) begin
          hr = '0;
        end else begin
          hr = N'($urandom_range(0, (1 << N) - 1)) & ~(N'(1) << w);
        end
        bus.hold_req = hr;
        if ((e > a_edge) && (e <= a_edge + m)) bus.cpu_idle = 1'b0;
        else if (e == a_edge + m + 1) bus.cpu_idle = 1'b1;
        else bus.cpu_idle = 1'($urandom_range(0, 1));
        if ((e == cur + 1) || (coinc && !abort && (e == g_edge + int'(MH)))) bus.clr_overrun = '1;
        else bus.clr_overrun = '0;
        tick();
      end

      if (abort) begin
        ready = drop + 1;
      end else begin
        last  = w;
        ready = n_edge + 2 + int'(CS);
      end
      cur = drop;
    end

    bus.hold_req    = '0;
    bus.clr_overrun = '0;
    bus.cpu_idle    = 1'b1;
    repeat (CS + 10) tick();
    chk("txn_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Asynchronous reset in the middle of a grant, then the first-tie rule.
    bus.hold_req = 3'b010;
    for (int i = 0; (i < 10) && (bus.hold_ack == '0); i++) tick();
    chk("pre_reset_ack", int'(bus.hold_ack), 2);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_hold_ack", int'(bus.hold_ack), 0);
    chk("async_rst_cpu_stall", int'(bus.cpu_stall), 0);
    chk("async_rst_bus_owner", int'(bus.bus_owner), 0);
    chk("async_rst_irq", int'(bus.irq), 0);
    bus.hold_req = 3'b011;
    tick();
    tick();
    reset_n = 1'b1;
    rst_cyc = cyc;
    for (int i = 0; (i < 10) && (bus.hold_ack == '0); i++) tick();
    chk("post_reset_first_ack", int'(bus.hold_ack), 1);
    chk("post_reset_latency", cyc - rst_cyc, 2);
    bus.hold_req = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at cyc %0d: got timeout, expected completion", cyc);
    $fatal(1);
  end

endmodule
